// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the round-robin bus router.
//   ID_W       width of the destination ID field at the top of each packet
//   MAX_DRVRS  widest request vector rr_next() can arbitrate
//   bus_st_e   per-bus sequencer state
//   rr_next    one-hot grant to the first requester at/after ptr (wrapping mod n)
package bus_arb_pkg;

   localparam int ID_W      = 8;
   localparam int MAX_DRVRS = 32;
   localparam int MAX_IDX_W = $clog2(MAX_DRVRS);

   typedef enum logic [1:0] {
      IDLE,
      POP,
      ROUTE
   } bus_st_e;

   function automatic logic [MAX_DRVRS-1:0] rr_next(
      input logic [MAX_DRVRS-1:0] req,
      input int                   ptr,
      input int                   n
   );
      logic [MAX_DRVRS-1:0] gnt;
      logic                 found;
      int                   idx;
      gnt   = '0;
      found = 1'b0;
      for (int i = 0; i < MAX_DRVRS; i++) begin
         // ptr < n, so one subtraction is enough to wrap
         idx = ptr + i;
         if (idx >= n) idx = idx - n;
         if (i < n && !found && req[idx[MAX_IDX_W-1:0]]) begin
            gnt[idx[MAX_IDX_W-1:0]] = 1'b1;
            found                   = 1'b1;
         end
      end
      return gnt;
   endfunction

endpackage

// File: rtl/bus_rr_router_if.sv
// Device-side bus bundle for bus_rr_router.
//   pndng   device FIFO non-empty            (device -> router)
//   D_pop   head-of-FIFO data                (device -> router)
//   pop     1-cycle dequeue strobe           (router -> device)
//   push    1-cycle enqueue strobe           (router -> device)
//   D_push  delivered packet, same per bus   (router -> device)
// Modport master is the router side, slave is the device side.
interface bus_rr_router_if #(
   parameter int bits    = 1,
   parameter int drvrs   = 4,
   parameter int pckg_sz = 16
);
   logic [bits-1:0][drvrs-1:0]              pndng;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop;
   logic [bits-1:0][drvrs-1:0]              pop;
   logic [bits-1:0][drvrs-1:0]              push;
   logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_push;

   modport master (input pndng, D_pop, output pop, push, D_push);
   modport slave  (output pndng, D_pop, input pop, push, D_push);
endinterface

// File: rtl/bus_rr_router_arbiter.sv
// rr_arbiter: round-robin grant for one bus.
//   clk, reset  clock, async active-high reset (pointer back to 0)
//   req_i       per-device request
//   adv_i       grant is being taken; move pointer past the winner
//   gnt_o       one-hot grant (combinational from req_i and pointer)
//   src_o       index of the granted device
module rr_arbiter
   import bus_arb_pkg::*;
#(
   parameter int drvrs = 4,
   parameter int PTR_W = (drvrs > 1) ? $clog2(drvrs) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [drvrs-1:0] req_i,
   input  logic             adv_i,
   output logic [drvrs-1:0] gnt_o,
   output logic [PTR_W-1:0] src_o
);

   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [MAX_DRVRS-1:0] req_ext, gnt_ext;

   always_comb begin
      req_ext              = '0;
      req_ext[drvrs-1:0]   = req_i;
      gnt_ext              = rr_next(req_ext, int'(ptr_q), drvrs);
      gnt_o                = gnt_ext[drvrs-1:0];
      src_o                = '0;
      for (int i = 0; i < drvrs; i++)
         if (gnt_o[i]) src_o = PTR_W'(i);
      ptr_d = ptr_q;
      if (adv_i && |gnt_o)
         ptr_d = (src_o == PTR_W'(drvrs - 1)) ? '0 : src_o + PTR_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) ptr_q <= '0;
      else       ptr_q <= ptr_d;
   end

endmodule

// File: rtl/bus_rr_router.sv
// bus_rr_router: per bus, grant one pending device round-robin, pop its
// packet, decode the destination ID and push to one device or broadcast.
//   clk, reset  single clock, async active-high reset
//   bus         bus_rr_router_if.master (pndng/D_pop in, pop/push/D_push out)
//   pkt_cnt     [bits][32] delivered packets   (only with BUS_ARB_STATS_EN)
//   drop_cnt    [bits][32] invalid-ID packets  (only with BUS_ARB_STATS_EN)
// Optional feature macro: BUS_ARB_STATS_EN (saturating statistics counters).
//
// state | meaning
// IDLE  | waiting for any pndng; grants next requester round-robin
// POP   | pop strobe out to src; packet captured at the closing edge
// ROUTE | push strobe(s) and D_push out for the captured packet
module bus_rr_router
   import bus_arb_pkg::*;
#(
   parameter int            bits      = 1,
   parameter int            drvrs     = 4,
   parameter int            pckg_sz   = 16,
   parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
   input  logic                 clk,
   input  logic                 reset,
   bus_rr_router_if.master      bus
`ifdef BUS_ARB_STATS_EN
   ,
   output logic [bits-1:0][31:0] pkt_cnt,
   output logic [bits-1:0][31:0] drop_cnt
`endif
);

   localparam int PTR_W = (drvrs > 1) ? $clog2(drvrs) : 1;

   for (genvar b = 0; b < bits; b++) begin : g_bus
      bus_st_e            st_q, st_d;
      logic [drvrs-1:0]   gnt, pop_q, pop_d, push_q, push_d;
      logic [PTR_W-1:0]   src, src_q, src_d;
      logic [pckg_sz-1:0] pkt, dpush_q, dpush_d;
      logic [ID_W-1:0]    id;
      logic               capture, deliver;

      rr_arbiter #(.drvrs(drvrs), .PTR_W(PTR_W)) u_arb (
         .clk   (clk),
         .reset (reset),
         .req_i (bus.pndng[b]),
         .adv_i (st_q == IDLE),
         .gnt_o (gnt),
         .src_o (src)
      );

      assign pkt     = bus.D_pop[b][src_q];
      assign id      = pkt[pckg_sz-1 -: ID_W];
      // a source that withdrew its request during POP is not captured
      assign capture = (st_q == POP) && bus.pndng[b][src_q];

      always_comb begin
         st_d    = st_q;
         pop_d   = '0;
         push_d  = '0;
         src_d   = src_q;
         dpush_d = dpush_q;
         deliver = 1'b0;
         case (st_q)
            IDLE: begin
               if (|bus.pndng[b]) begin
                  src_d = src;
                  pop_d = gnt;
                  st_d  = POP;
               end
            end
            POP: begin
               st_d = capture ? ROUTE : IDLE;
               if (capture) begin
                  if (int'(id) < drvrs) begin
                     for (int i = 0; i < drvrs; i++)
                        push_d[i] = (int'(id) == i);
                     deliver = 1'b1;
                  end else if (id == broadcast) begin
                     // pop_q is still the one-hot source
                     push_d  = ~pop_q;
                     deliver = 1'b1;
                  end
               end
            end
            ROUTE:   st_d = IDLE;
            default: st_d = IDLE;
         endcase
         // dropped packets leave D_push at its previous value
         if (deliver) dpush_d = pkt;
      end

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            st_q    <= IDLE;
            pop_q   <= '0;
            push_q  <= '0;
            src_q   <= '0;
            dpush_q <= '0;
         end else begin
            st_q    <= st_d;
            pop_q   <= pop_d;
            push_q  <= push_d;
            src_q   <= src_d;
            dpush_q <= dpush_d;
         end
      end

      assign bus.pop[b]  = pop_q;
      assign bus.push[b] = push_q;
      for (genvar d = 0; d < drvrs; d++) begin : g_dpush
         assign bus.D_push[b][d] = dpush_q;
      end

`ifdef BUS_ARB_STATS_EN
      logic [31:0] pkt_q, drop_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            pkt_q  <= '0;
            drop_q <= '0;
         end else begin
            if (deliver && pkt_q != '1)             pkt_q  <= pkt_q + 32'd1;
            if (capture && !deliver && drop_q != '1) drop_q <= drop_q + 32'd1;
         end
      end

      assign pkt_cnt[b]  = pkt_q;
      assign drop_cnt[b] = drop_q;
`endif
   end

endmodule
